// File: rtl/opti_sos_outstage_if.sv
// Sample stream bundle for the SOS output stage: the un-backpressured sample input
// from the last biquad and the valid/ready output stream toward the DAC side.
interface opti_sos_outstage_if #(
    parameter int OUT_W = 16
);
    logic signed [23:0]      data_in;
    logic                    valid_in;
    logic signed [23:0]      gain;
    logic signed [OUT_W-1:0] out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  data_in, valid_in, gain, out_ready,
        output out_data, out_valid
    );

    modport master (
        output data_in, valid_in, gain, out_ready,
        input  out_data, out_valid
    );
endinterface

// File: rtl/opti_sos_outstage.sv
// Output stage after the last SOS biquad: gain multiply, round-half-up and saturate
// to OUT_W bits, then a first-word-fall-through FIFO that drops and counts on overflow.
module opti_sos_outstage #(
    parameter int OUT_W      = 16,
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    opti_sos_outstage_if.slave    io,
    input  logic                  clr_flags,
    output logic [AW:0]           fifo_count,
    output logic                  sat_flag,
    output logic [15:0]           drop_cnt
);
    localparam int SH = 44 - (OUT_W - 1);
    localparam logic signed [47:0] HALF  = 48'sd1 <<< (SH - 1);
    localparam logic signed [47:0] MAX_V = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
    localparam logic signed [47:0] MIN_V = -(48'sd1 <<< (OUT_W - 1));
    localparam logic [AW:0]        PTR_ONE = 1;

    // S1: Q2.22 x Q2.22 -> Q4.44; the gain is captured with the sample it scales
    logic signed [47:0] prod_q;
    logic               v1_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            prod_q <= '0;
        end else begin
            v1_q <= io.valid_in;
            if (io.valid_in)
                prod_q <= 48'(io.data_in) * 48'(io.gain);
        end
    end

    // S2: round half-up at full 48-bit width, then clamp to the output range
    logic signed [47:0]      rnd;
    logic signed [OUT_W-1:0] sat_val;
    logic                    clamp;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        rnd     = (prod_q + HALF) >>> SH;
        sat_val = rnd[OUT_W-1:0];
        clamp   = 1'b0;
        if (rnd > MAX_V) begin
            sat_val = MAX_V[OUT_W-1:0];
            clamp   = 1'b1;
        end else if (rnd < MIN_V) begin
            sat_val = MIN_V[OUT_W-1:0];
            clamp   = 1'b1;
        end
    end

    logic signed [OUT_W-1:0] s2_q;
    logic                    v2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_q <= 1'b0;
            s2_q <= '0;
        end else begin
            v2_q <= v1_q;
            if (v1_q)
                s2_q <= sat_val;
        end
    end

    // FIFO with one extra wrap bit on each pointer
    logic [AW:0]             wr_ptr, rd_ptr, rd_nxt;
    logic signed [OUT_W-1:0] mem [FIFO_DEPTH];
    logic signed [OUT_W-1:0] head_q;
    logic                    full, empty, push, pop, drop;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop        = !empty && io.out_ready;
    assign push       = v2_q && (!full || pop);
    assign drop       = v2_q && full && !pop;
    assign rd_nxt     = rd_ptr + PTR_ONE;
    assign fifo_count = wr_ptr - rd_ptr;

    // NOTE: the storage array has no reset; only pointers define which words are live.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_nxt;
        end
    end

    // Registered head: a word landing in an empty (or emptying) FIFO bypasses the array
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
        end else if (pop) begin
            if (fifo_count == PTR_ONE) begin
                if (push) head_q <= s2_q;
            end else begin
                head_q <= mem[rd_nxt[AW-1:0]];
            end
        end else if (empty && push) begin
            head_q <= s2_q;
        end
    end

    assign io.out_data  = head_q;
    assign io.out_valid = !empty;

    // Sticky status; a clear in the same cycle as an event wins
    always_ff @(posedge clk) begin
        if (rst || clr_flags) begin
            sat_flag <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (v1_q && clamp)
                sat_flag <= 1'b1;
            if (drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
endmodule
